stc_out_collector: RTL and testbench

- Receiving end of the sparse tensor core reduction bus: accepts the N_BUSLINE-lane result vector and per-lane valid mask from the fan tree.
- Captures one vector into a holding bank, then drains the valid lanes lowest-index-first as a serial ready/valid stream of (lane index, value, vector sequence number) to the output buffer writer.
- Applies backpressure to the core through in_ready.

---
 rtl/stc_pkg.sv | 21 ++
 rtl/stc_lane_prio_enc.sv | 26 ++
 rtl/stc_out_collector.sv | 84 ++++++++
 tb/tb_stc_out_collector.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stc_pkg.sv
// Shared definitions for the sparse tensor core output path.
// Sizing defaults, bus-width derivation and FSM encoding.
package stc_pkg;

  localparam int STC_N_UNIT  = 32;
  localparam int STC_DW_DATA = 32;
  localparam int STC_SEQ_W   = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Reduction bus carries two lanes per adder of the fan tree.
  function automatic int stc_n_busline(input int n_unit);
    return 2 * (n_unit - 1);
  endfunction

  function automatic int stc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stc_lane_prio_enc.sv
// Lowest-set-bit priority encoder over a lane mask.
// Also flags an empty mask and a mask with exactly one bit set.
module stc_lane_prio_enc
  import stc_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = stc_idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic          one_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o = |req_i;
  // Clearing the lowest set bit leaves nothing iff one bit was set.
  assign one_o = any_o & ((req_i & (req_i - N'(1))) == '0);

endmodule

// File: rtl/stc_out_collector.sv
// Reduction bus collector: captures one lane vector, then drains
// its valid lanes lowest-first as a serial ready/valid stream.
module stc_out_collector
  import stc_pkg::*;
#(
  parameter int N_UNIT  = STC_N_UNIT,
  parameter int DW_DATA = STC_DW_DATA,
  parameter int SEQ_W   = STC_SEQ_W,
  localparam int N_BUSLINE = stc_n_busline(N_UNIT),
  localparam int IDX_W     = stc_idx_w(N_BUSLINE)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_BUSLINE*DW_DATA-1:0]   in_bus,
  input  logic [N_BUSLINE-1:0]           in_valid,
  output logic                           in_ready,
  output logic signed [DW_DATA-1:0]      out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic [SEQ_W-1:0]               out_seq,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  logic [0:0]                   state_q, state_d;
  logic [N_BUSLINE-1:0]         pend_q, pend_d;
  logic [SEQ_W-1:0]             seq_q, seq_d;
  logic [N_BUSLINE*DW_DATA-1:0] bank_q;

  logic [IDX_W-1:0] idx;
  logic             any, one;
  logic             out_fire, pop_last, in_fire;

  stc_lane_prio_enc #(.N(N_BUSLINE)) u_enc (
    .req_i (pend_q),
    .idx_o (idx),
    .any_o (any),
    .one_o (one)
  );

  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = out_valid & one;
  assign out_idx   = idx;
  assign out_data  = bank_q[idx*DW_DATA +: DW_DATA];
  assign out_seq   = seq_q;
  assign busy      = any;

  assign out_fire = out_valid & out_ready;
  assign pop_last = out_fire & out_last;
  // Accepting during the final pop avoids a bubble between vectors.
  assign in_ready = (state_q == ST_IDLE) | pop_last;
  assign in_fire  = (|in_valid) & in_ready;

  always_comb begin
    pend_d  = pend_q;
    state_d = state_q;
    seq_d   = seq_q;
    if (out_fire) pend_d[idx] = 1'b0;
    if (pop_last) begin
      seq_d   = seq_q + 1'b1;
      state_d = ST_IDLE;
    end
    if (in_fire) begin
      pend_d  = in_valid;
      state_d = ST_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      seq_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      seq_q   <= seq_d;
      if (in_fire) bank_q <= in_bus;
    end
  end

endmodule

// File: tb/tb_stc_out_collector.sv
// Self-checking bench for stc_out_collector (6-lane configuration).
// Directed scenarios plus a randomized run against a beat-queue model.
module tb_stc_out_collector;

  localparam int NB = 6;
  localparam int DW = 32;

  logic              clk;
  logic              reset;
  logic [NB*DW-1:0]  bus;
  logic [NB-1:0]     vmask;
  logic              ordy;
  logic              in_ready;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_idx;
  logic [7:0]        out_seq;
  logic              out_last;
  logic              out_valid;
  logic              busy;

  logic [NB*DW-1:0]  w_bus;
  logic [NB-1:0]     w_mask;
  logic              w_rdy;
  logic              w_in_ready;
  logic [DW-1:0]     w_data;
  logic [2:0]        w_idx;
  logic [1:0]        w_seq;
  logic              w_last;
  logic              w_valid;
  logic              w_busy;

  int total = 0;
  int bad   = 0;
  int mseq  = 0;

  stc_out_collector #(.N_UNIT(4), .DW_DATA(DW), .SEQ_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (bus),
    .in_valid  (vmask),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_seq   (out_seq),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (ordy),
    .busy      (busy)
  );

  stc_out_collector #(.N_UNIT(4), .DW_DATA(DW), .SEQ_W(2)) u_w (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (w_bus),
    .in_valid  (w_mask),
    .in_ready  (w_in_ready),
    .out_data  (w_data),
    .out_idx   (w_idx),
    .out_seq   (w_seq),
    .out_last  (w_last),
    .out_valid (w_valid),
    .out_ready (w_rdy),
    .busy      (w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, in_ready, idx, data, seq, last}
  logic [45:0] cur;
  assign cur = {out_valid, in_ready, out_idx, out_data, out_seq, out_last};

  function automatic logic [45:0] ex(bit v, bit r, int i,
                                     logic [31:0] d, int s, bit l);
    return {v, r, 3'(i), d, 8'(s), l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_basic_lanes();
    for (int i = 0; i < NB; i++) bus[i*DW +: DW] = 32'((i + 1) * 10);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({out_valid, out_last, out_data, out_idx, out_seq, busy, in_ready}
        !== {1'b0, 1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_during got v=%b l=%b d=%h i=%0d s=%0d b=%b r=%b",
               out_valid, out_last, out_data, out_idx, out_seq, busy, in_ready);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, out_data, out_idx, out_seq, busy, in_ready}
        !== {1'b0, 1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_after got v=%b l=%b d=%h i=%0d s=%0d b=%b r=%b",
               out_valid, out_last, out_data, out_idx, out_seq, busy, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [45:0] e;
    tick();
    set_basic_lanes();
    vmask = 6'b100101;
    ordy = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready got=%b exp=1", in_ready);
    end
    tick();
    vmask = '0;
    #1;
    e = ex(1, 0, 0, 10, mseq, 0);
    total++;
    if (cur !== e) begin bad++; $display("FAIL basic_b0 got=%h exp=%h", cur, e); end
    tick();
    e = ex(1, 0, 2, 30, mseq, 0);
    total++;
    if (cur !== e) begin bad++; $display("FAIL basic_b1 got=%h exp=%h", cur, e); end
    tick();
    e = ex(1, 1, 5, 60, mseq, 1);
    total++;
    if (cur !== e) begin bad++; $display("FAIL basic_b2 got=%h exp=%h", cur, e); end
    tick();
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL basic_idle got=%b exp=010", {out_valid, in_ready, busy});
    end
    mseq++;
  endtask

  task automatic test_backpressure();
    logic [45:0] e;
    tick();
    set_basic_lanes();
    vmask = 6'b100101;
    ordy = 1'b1;
    tick();
    bus[1*DW +: DW] = 32'd77;
    vmask = 6'b000010;
    #1;
    e = ex(1, 0, 0, 10, mseq, 0);
    total++;
    if (cur !== e) begin bad++; $display("FAIL bp_b0 got=%h exp=%h", cur, e); end
    tick();
    ordy = 1'b0;
    #1;
    e = ex(1, 0, 2, 30, mseq, 0);
    total++;
    if (cur !== e) begin bad++; $display("FAIL bp_hold0 got=%h exp=%h", cur, e); end
    for (int k = 1; k < 3; k++) begin
      tick();
      total++;
      if (cur !== e) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", k, cur, e); end
    end
    tick();
    ordy = 1'b1;
    #1;
    total++;
    if (cur !== e) begin bad++; $display("FAIL bp_release got=%h exp=%h", cur, e); end
    tick();
    e = ex(1, 1, 5, 60, mseq, 1);
    total++;
    if (cur !== e) begin bad++; $display("FAIL bp_last got=%h exp=%h", cur, e); end
    tick();
    vmask = '0;
    #1;
    e = ex(1, 1, 1, 77, mseq + 1, 1);
    total++;
    if (cur !== e) begin bad++; $display("FAIL bp_second got=%h exp=%h", cur, e); end
    tick();
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL bp_idle got=%b exp=010", {out_valid, in_ready, busy});
    end
    mseq += 2;
  endtask

  task automatic test_back_to_back();
    logic [45:0] e;
    tick();
    bus[0 +: DW] = -32'sd7;
    vmask = 6'b000001;
    ordy = 1'b1;
    tick();
    bus[4*DW +: DW] = 32'd44;
    bus[5*DW +: DW] = 32'd55;
    vmask = 6'b110000;
    #1;
    e = ex(1, 1, 0, 32'hFFFF_FFF9, mseq, 1);
    total++;
    if (cur !== e) begin bad++; $display("FAIL b2b_a got=%h exp=%h", cur, e); end
    tick();
    vmask = '0;
    #1;
    e = ex(1, 0, 4, 44, mseq + 1, 0);
    total++;
    if (cur !== e) begin bad++; $display("FAIL b2b_b0 got=%h exp=%h", cur, e); end
    tick();
    e = ex(1, 1, 5, 55, mseq + 1, 1);
    total++;
    if (cur !== e) begin bad++; $display("FAIL b2b_b1 got=%h exp=%h", cur, e); end
    tick();
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL b2b_idle got=%b exp=010", {out_valid, in_ready, busy});
    end
    mseq += 2;
  endtask

  task automatic test_empty_all();
    logic [31:0] vals [NB];
    logic [45:0] e;
    for (int k = 0; k < 5; k++) begin
      tick();
      vmask = '0;
      for (int i = 0; i < NB; i++) bus[i*DW +: DW] = $urandom;
      ordy = 1'b1;
      #1;
      total++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        bad++;
        $display("FAIL empty_%0d got=%b exp=010", k, {out_valid, in_ready, busy});
      end
    end
    tick();
    vmask = 6'b111111;
    for (int i = 0; i < NB; i++) begin
      vals[i] = $urandom;
      bus[i*DW +: DW] = vals[i];
    end
    for (int i = 0; i < NB; i++) begin
      tick();
      if (i == 0) vmask = '0;
      #1;
      e = ex(1, i == NB - 1, i, vals[i], mseq, i == NB - 1);
      total++;
      if (cur !== e) begin bad++; $display("FAIL all_b%0d got=%h exp=%h", i, cur, e); end
    end
    tick();
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL all_idle got=%b exp=010", {out_valid, in_ready, busy});
    end
    mseq++;
  endtask

  task automatic test_reset_mid();
    logic [45:0] e;
    tick();
    set_basic_lanes();
    vmask = 6'b100101;
    ordy = 1'b1;
    tick();
    vmask = '0;
    #1;
    e = ex(1, 0, 0, 10, mseq, 0);
    total++;
    if (cur !== e) begin bad++; $display("FAIL rm_b0 got=%h exp=%h", cur, e); end
    tick();
    e = ex(1, 0, 2, 30, mseq, 0);
    total++;
    if (cur !== e) begin bad++; $display("FAIL rm_b1 got=%h exp=%h", cur, e); end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({out_valid, out_last, out_data, out_idx, out_seq, busy, in_ready}
        !== {1'b0, 1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rm_async got v=%b l=%b d=%h i=%0d s=%0d b=%b r=%b",
               out_valid, out_last, out_data, out_idx, out_seq, busy, in_ready);
    end
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_seq, busy, in_ready} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rm_release got v=%b s=%0d b=%b r=%b",
               out_valid, out_seq, busy, in_ready);
    end
    mseq = 0;
  endtask

  task automatic test_seq_wrap();
    logic [38:0] got, e;
    w_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      w_mask = 6'(1 << k);
      w_bus[k*DW +: DW] = 32'(100 + k);
      tick();
      w_mask = '0;
      #1;
      got = {w_valid, w_idx, w_data, w_seq, w_last};
      e = {1'b1, 3'(k), 32'(100 + k), 2'(k % 4), 1'b1};
      total++;
      if (got !== e) begin bad++; $display("FAIL wrap_%0d got=%h exp=%h", k, got, e); end
    end
    tick();
  endtask

  task automatic test_random();
    logic [43:0] exp_q [$];
    logic [43:0] beat;
    bit ev, er;
    int hi;
    for (int c = 0; c < 400; c++) begin
      tick();
      vmask = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      for (int i = 0; i < NB; i++) bus[i*DW +: DW] = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      ev = (exp_q.size() != 0);
      er = !ev || (exp_q.size() == 1 && ordy);
      total++;
      if ({out_valid, in_ready, busy} !== {ev, er, ev}) begin
        bad++;
        $display("FAIL rnd_ctl c=%0d got=%b exp=%b", c,
                 {out_valid, in_ready, busy}, {ev, er, ev});
      end
      if (ev) begin
        beat = {out_idx, out_data, out_seq, out_last};
        total++;
        if (beat !== exp_q[0]) begin
          bad++;
          $display("FAIL rnd_beat c=%0d got=%h exp=%h", c, beat, exp_q[0]);
        end
        if (ordy) void'(exp_q.pop_front());
      end
      if (vmask != 0 && er) begin
        hi = 0;
        for (int i = 0; i < NB; i++) if (vmask[i]) hi = i;
        for (int i = 0; i < NB; i++)
          if (vmask[i])
            exp_q.push_back({3'(i), bus[i*DW +: DW], 8'(mseq), i == hi});
        mseq = (mseq + 1) % 256;
      end
    end
    tick();
    vmask = '0;
  endtask

  initial begin
    reset  = 1'b1;
    bus    = '0;
    vmask  = '0;
    ordy   = 1'b0;
    w_bus  = '0;
    w_mask = '0;
    w_rdy  = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_empty_all();
    test_reset_mid();
    test_seq_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
